// File: rtl/awg_seq_pkg.sv
// Shared types and default widths for the AWG ROM waveform sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package awg_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_PHASE_W = 24;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/awg_phase_acc.sv
// DDS phase accumulator: phase register, adder with carry-out, ROM address slice.
// Latency: load/advance take effect at the next clka edge; carry and addr are combinational.
// Backpressure: none; the parent only asserts adv when a sample slot is free.
module awg_phase_acc
    import awg_seq_pkg::*;
#(
    parameter int P_ADDR_WIDTH  = DEF_ADDR_W,
    parameter int P_PHASE_WIDTH = DEF_PHASE_W
) (
    input  logic                     clka,
    input  logic                     rsta,
    input  logic                     load,
    input  logic                     adv,
    input  logic [P_PHASE_WIDTH-1:0] load_val,
    input  logic [P_PHASE_WIDTH-1:0] ftw,
    output logic [P_ADDR_WIDTH-1:0]  addr,
    output logic                     carry
);

    logic [P_PHASE_WIDTH-1:0] phase;
    logic [P_PHASE_WIDTH:0]   sum;

    // One extra bit on the adder gives the period-wrap carry for free.
    assign sum   = {1'b0, phase} + {1'b0, ftw};
    assign carry = sum[P_PHASE_WIDTH];
    assign addr  = phase[P_PHASE_WIDTH-1 -: P_ADDR_WIDTH];

    // Phase register: load at burst start, otherwise step by ftw on each issue.
    always_ff @(posedge clka) begin
        if (rsta) begin
            phase <= '0;
        end else if (load) begin
            phase <= load_val;
        end else if (adv) begin
            phase <= sum[P_PHASE_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/awg_rom_seq.sv
// Waveform sequencer driving a read-latency-1 ROM from a DDS phase accumulator.
// Latency: start to first smp_valid is 2 cycles; 1 sample/cycle with smp_ready high.
// Backpressure: smp_ready low re-presents last_addr to the ROM so smp_data holds.
module awg_rom_seq
    import awg_seq_pkg::*;
#(
    parameter int P_ADDR_WIDTH  = DEF_ADDR_W,
    parameter int P_DATA_WIDTH  = DEF_DATA_W,
    parameter int P_PHASE_WIDTH = DEF_PHASE_W,
    parameter int P_CNT_WIDTH   = DEF_CNT_W
) (
    input  logic                     clka,
    input  logic                     rsta,
    input  logic [P_PHASE_WIDTH-1:0] cfg_ftw,
    input  logic [P_PHASE_WIDTH-1:0] cfg_phase_ofs,
    input  logic [P_CNT_WIDTH-1:0]   cfg_cycles,
    input  logic                     start,
    input  logic                     stop,
    output logic                     busy,
    output logic                     done,
    output logic [P_ADDR_WIDTH-1:0]  rom_addr,
    input  logic [P_DATA_WIDTH-1:0]  rom_data,
    output logic [P_DATA_WIDTH-1:0]  smp_data,
    output logic                     smp_valid,
    input  logic                     smp_ready
);

    seq_state_t               state;
    logic [P_PHASE_WIDTH-1:0] ftw_q;
    logic [P_CNT_WIDTH-1:0]   cycles_q;
    logic [P_CNT_WIDTH-1:0]   cnt;
    logic [P_CNT_WIDTH:0]     cnt_nxt;
    logic [P_ADDR_WIDTH-1:0]  last_addr;
    logic [P_ADDR_WIDTH-1:0]  issue_addr;
    logic                     carry;
    logic                     load;
    logic                     adv;
    logic                     hs;
    logic                     last_period;

    assign load = (state == IDLE) && start;
    assign adv  = (state == RUN) && !stop && (!smp_valid || smp_ready);
    assign hs   = smp_valid && smp_ready;

    // Widened increment so a saturated cnt can never alias onto cfg_cycles.
    assign cnt_nxt     = {1'b0, cnt} + 1'b1;
    assign last_period = carry && (cycles_q != '0) && (cnt_nxt == {1'b0, cycles_q});

    // Stalled: the ROM recaptures the previous address so its output holds.
    assign rom_addr = adv ? issue_addr : last_addr;
    assign smp_data = rom_data;
    assign busy     = (state != IDLE);

    awg_phase_acc #(
        .P_ADDR_WIDTH  (P_ADDR_WIDTH),
        .P_PHASE_WIDTH (P_PHASE_WIDTH)
    ) u_phase_acc (
        .clka     (clka),
        .rsta     (rsta),
        .load     (load),
        .adv      (adv),
        .load_val (cfg_phase_ofs),
        .ftw      (ftw_q),
        .addr     (issue_addr),
        .carry    (carry)
    );

    // Burst FSM with period counter, issued-address history and sample valid.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state     <= IDLE;
            ftw_q     <= '0;
            cycles_q  <= '0;
            cnt       <= '0;
            last_addr <= '0;
            smp_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ftw_q    <= cfg_ftw;
                        cycles_q <= cfg_cycles;
                        cnt      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        // A beat accepted in this same cycle needs no drain.
                        if (smp_valid && !smp_ready) begin
                            state <= DRAIN;
                        end else begin
                            smp_valid <= 1'b0;
                            state     <= IDLE;
                            done      <= 1'b1;
                        end
                    end else if (adv) begin
                        last_addr <= issue_addr;
                        smp_valid <= 1'b1;
                        if (carry) begin
                            if (!(&cnt)) begin
                                cnt <= cnt_nxt[P_CNT_WIDTH-1:0];
                            end
                            if (last_period) begin
                                state <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (hs) begin
                        smp_valid <= 1'b0;
                        state     <= IDLE;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_awg_rom_seq.sv
// Self-checking bench for awg_rom_seq against a phase-arithmetic reference model.
// Latency: checks first valid 2 cycles after start, done 1 cycle after last beat.
// Backpressure: fixed and random smp_ready patterns, stall-hold checked each cycle.
module tb_awg_rom_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] cfg_ftw;
    logic [23:0] cfg_phase_ofs;
    logic [15:0] cfg_cycles;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  smp_data;
    logic        smp_valid;
    logic        smp_ready;
    logic [7:0]  rom_q = 8'd0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int first_valid, last_hs, done_cyc, done_cnt, stall_err, stop_addr;
    logic busy_at_done, timed_out;

    always #5 clk = ~clk;

    // ROM model: read latency 1, content equals address.
    always @(posedge clk) rom_q <= rom_addr;
    assign rom_data = rom_q;

    awg_rom_seq dut (
        .clka          (clk),
        .rsta          (rst),
        .cfg_ftw       (cfg_ftw),
        .cfg_phase_ofs (cfg_phase_ofs),
        .cfg_cycles    (cfg_cycles),
        .start         (start),
        .stop          (stop),
        .busy          (busy),
        .done          (done),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .smp_data      (smp_data),
        .smp_valid     (smp_valid),
        .smp_ready     (smp_ready)
    );

    // Reference: walk the phase with plain 24-bit arithmetic, count wraps as periods.
    task automatic build_model(input int unsigned ftw, input int unsigned ofs,
                               input int unsigned cyc, input int maxn);
        int unsigned p, s, n;
        exp_q.delete();
        p = ofs;
        n = 0;
        while (exp_q.size() < maxn) begin
            exp_q.push_back(p[23:16]);
            s = p + ftw;
            if (s >= 32'h0100_0000) n++;
            p = s & 32'h00FF_FFFF;
            if (cyc != 0 && n == cyc) break;
        end
    endtask

    function automatic int seq_mismatch();
        if (got_q.size() != exp_q.size()) return -2;
        foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // Drive one burst and record every accepted beat and timing marker.
    task automatic run_burst(input logic [23:0] ftw, input logic [23:0] ofs,
                             input logic [15:0] cyc, input int rmode,
                             input int stop_after, input int ign_at, input int budget);
        int hs;
        int ph;
        logic prev_stall;
        logic [7:0] prev_dat;
        got_q.delete();
        first_valid = -1; last_hs = -1; done_cyc = -1; done_cnt = 0;
        stall_err = 0; stop_addr = -1; busy_at_done = 1'b1; timed_out = 1'b0;
        hs = 0; prev_stall = 1'b0; prev_dat = 8'd0;
        @(negedge clk);
        cfg_ftw = ftw; cfg_phase_ofs = ofs; cfg_cycles = cyc;
        start = 1'b1; stop = 1'b0; smp_ready = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (ign_at > 0 && k >= ign_at && k < ign_at + 3) begin
                start = 1'b1;
                cfg_ftw = 24'h100000; cfg_phase_ofs = 24'h123456; cfg_cycles = 16'd3;
            end else begin
                start = 1'b0;
            end
            stop = (stop_after > 0 && hs >= stop_after);
            ph = (k - 1) % 4;
            case (rmode)
                0:       smp_ready = 1'b1;
                1:       smp_ready = (ph == 0 || ph == 3);
                default: smp_ready = 1'($urandom_range(1, 0));
            endcase
            #1;
            if (prev_stall && smp_data !== prev_dat) stall_err++;
            if (smp_valid === 1'b1 && first_valid < 0) first_valid = k;
            if (stop && stop_addr < 0) stop_addr = int'(rom_addr);
            if (smp_valid === 1'b1 && smp_ready) begin
                got_q.push_back(smp_data);
                last_hs = k;
                hs++;
            end
            prev_stall = (smp_valid === 1'b1) && !smp_ready;
            prev_dat = smp_data;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    busy_at_done = busy;
                end
            end
            if (done_cyc >= 0 && k >= done_cyc + 2) break;
        end
        if (done_cyc < 0) timed_out = 1'b1;
        start = 1'b0; stop = 1'b0; smp_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || smp_valid !== 1'b0 || rom_addr !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b valid=%b addr=%0h, required 0 0 0 0",
                     busy, done, smp_valid, rom_addr);
        end
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || smp_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b valid=%b, required 0 0", busy, smp_valid);
        end
    endtask

    task automatic test_single_period();
        int mm;
        build_model(24'h010000, 0, 1, 100000);
        run_burst(24'h010000, 24'h0, 16'd1, 0, 0, 0, 2000);
        mm = seq_mismatch();
        checks++;
        if (timed_out) begin failures++; $display("FAIL single_timeout: no done within budget"); end
        checks++;
        if (got_q.size() != 256) begin
            failures++; $display("FAIL single_count: got %0d beats, required 256", got_q.size());
        end
        checks++;
        if (mm >= 0) begin
            failures++; $display("FAIL single_seq: beat %0d = %0h, required %0h", mm, got_q[mm], exp_q[mm]);
        end
        checks++;
        if (first_valid != 2) begin
            failures++; $display("FAIL single_latency: first valid cycle %0d, required 2", first_valid);
        end
        checks++;
        if (done_cyc != last_hs + 1 || busy_at_done !== 1'b0 || done_cnt != 1) begin
            failures++;
            $display("FAIL single_done: done_cyc=%0d busy=%b pulses=%0d, required %0d 0 1",
                     done_cyc, busy_at_done, done_cnt, last_hs + 1);
        end
    endtask

    task automatic test_offset_step();
        int mm;
        build_model(24'h040000, 24'h800000, 2, 100000);
        run_burst(24'h040000, 24'h800000, 16'd2, 0, 0, 0, 2000);
        mm = seq_mismatch();
        checks++;
        if (got_q.size() != exp_q.size() || timed_out) begin
            failures++;
            $display("FAIL offset_count: got %0d beats (timeout=%b), required %0d",
                     got_q.size(), timed_out, exp_q.size());
        end
        checks++;
        if (mm >= 0) begin
            failures++; $display("FAIL offset_seq: beat %0d = %0h, required %0h", mm, got_q[mm], exp_q[mm]);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_hs + 1) begin
            failures++;
            $display("FAIL offset_done: pulses=%0d cycle=%0d, required 1 %0d", done_cnt, done_cyc, last_hs + 1);
        end
    endtask

    task automatic test_backpressure();
        int mm;
        build_model(24'h010000, 0, 1, 100000);
        run_burst(24'h010000, 24'h0, 16'd1, 1, 0, 0, 3000);
        mm = seq_mismatch();
        checks++;
        if (got_q.size() != 256 || timed_out) begin
            failures++;
            $display("FAIL bp_count: got %0d beats (timeout=%b), required 256", got_q.size(), timed_out);
        end
        checks++;
        if (mm >= 0) begin
            failures++; $display("FAIL bp_seq: beat %0d = %0h, required %0h", mm, got_q[mm], exp_q[mm]);
        end
        checks++;
        if (stall_err != 0) begin
            failures++; $display("FAIL bp_hold: %0d stalls changed smp_data, required 0", stall_err);
        end
    endtask

    task automatic test_stop();
        int mm;
        build_model(24'h010000, 0, 0, 11);
        run_burst(24'h010000, 24'h0, 16'd0, 0, 10, 0, 500);
        mm = seq_mismatch();
        checks++;
        if (got_q.size() != 11 || timed_out) begin
            failures++;
            $display("FAIL stop_count: got %0d beats (timeout=%b), required 11", got_q.size(), timed_out);
        end
        checks++;
        if (mm >= 0) begin
            failures++; $display("FAIL stop_seq: beat %0d = %0h, required %0h", mm, got_q[mm], exp_q[mm]);
        end
        checks++;
        if (stop_addr != int'(exp_q[10])) begin
            failures++; $display("FAIL stop_no_issue: rom_addr=%0h under stop, required %0h", stop_addr, exp_q[10]);
        end
        checks++;
        if (done_cnt != 1 || busy_at_done !== 1'b0) begin
            failures++; $display("FAIL stop_done: pulses=%0d busy=%b, required 1 0", done_cnt, busy_at_done);
        end
    endtask

    task automatic test_ftw_zero();
        int mm;
        build_model(0, 24'h5A1234, 0, 6);
        run_burst(24'h0, 24'h5A1234, 16'd0, 0, 5, 0, 300);
        mm = seq_mismatch();
        checks++;
        if (got_q.size() != 6 || mm >= 0 || timed_out) begin
            failures++;
            $display("FAIL ftw_zero: %0d beats first_bad=%0d timeout=%b, required 6 beats of 5a",
                     got_q.size(), mm, timed_out);
        end
    endtask

    task automatic test_reset_midburst();
        int dones;
        @(negedge clk);
        cfg_ftw = 24'h010000; cfg_phase_ofs = 24'h0; cfg_cycles = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || smp_valid !== 1'b0 || rom_addr !== 8'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midburst_reset: busy=%b valid=%b addr=%0h done=%b, required 0 0 0 0",
                     busy, smp_valid, rom_addr, done);
        end
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (done === 1'b1 || smp_valid === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++; $display("FAIL midburst_quiet: %0d cycles with done/valid after reset, required 0", dones);
        end
    endtask

    task automatic test_ignored_start();
        int mm;
        build_model(24'h010000, 0, 1, 100000);
        run_burst(24'h010000, 24'h0, 16'd1, 0, 0, 5, 2000);
        mm = seq_mismatch();
        checks++;
        if (got_q.size() != 256 || mm >= 0 || timed_out || done_cnt != 1) begin
            failures++;
            $display("FAIL ignored_start: %0d beats first_bad=%0d timeout=%b pulses=%0d, required 256 -1 0 1",
                     got_q.size(), mm, timed_out, done_cnt);
        end
    endtask

    task automatic test_random();
        logic [23:0] ftw, ofs;
        logic [15:0] cyc;
        int mm;
        for (int it = 0; it < 6; it++) begin
            ftw = 24'($urandom_range(32'hFF_FFFF, 32'h08_0000));
            ofs = 24'($urandom);
            cyc = 16'($urandom_range(3, 1));
            build_model(ftw, ofs, cyc, 100000);
            run_burst(ftw, ofs, cyc, 2, 0, 0, 3000);
            mm = seq_mismatch();
            checks++;
            if (got_q.size() != exp_q.size() || mm >= 0 || timed_out || stall_err != 0) begin
                failures++;
                $display("FAIL random_%0d: ftw=%0h ofs=%0h cyc=%0d beats=%0d/%0d first_bad=%0d timeout=%b stalls=%0d",
                         it, ftw, ofs, cyc, got_q.size(), exp_q.size(), mm, timed_out, stall_err);
            end
            checks++;
            if (first_valid != 2 || done_cyc != last_hs + 1 || done_cnt != 1) begin
                failures++;
                $display("FAIL random_timing_%0d: first=%0d done=%0d pulses=%0d, required 2 %0d 1",
                         it, first_valid, done_cyc, done_cnt, last_hs + 1);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; smp_ready = 1'b1;
        cfg_ftw = '0; cfg_phase_ofs = '0; cfg_cycles = '0;
        test_reset();
        test_single_period();
        test_offset_step();
        test_backpressure();
        test_stop();
        test_ftw_zero();
        test_reset_midburst();
        test_ignored_start();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
